// File: rtl/output_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : output_pulse_scheduler
// Description : Command FIFO feeding a small issue engine. Each command drives
//               a one-cycle update strobe with its shutter/counter words. A
//               timed pulse then counts down its duration and strobes
//               wait_expired. abort flushes everything. Reset is asynchronous
//               and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module output_pulse_scheduler #(
  parameter int DEPTH = 4,
  parameter int DUR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_shutter,
  input  logic [63:0]      cmd_counter,
  input  logic             cmd_pulse,
  input  logic [DUR_W-1:0] cmd_duration,
  input  logic             enable,
  input  logic             abort,
  output logic             update,
  output logic             pulse_mode,
  output logic [63:0]      shutter_value,
  output logic [63:0]      counter_value,
  output logic             wait_expired,
  output logic             busy,
  output logic             overflow
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam int c_ENT_W  = 64 + 64 + 1 + DUR_W;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_GAP    = 2'd2,
    ST_TIMING = 2'd3
  } state_t;

  state_t               r_state;
  logic [DUR_W-1:0]     r_timer;
  logic [DUR_W-1:0]     r_pend_len;
  logic                 r_update;
  logic                 r_wait;
  logic                 r_overflow;
  logic [c_ADDR_W-1:0]  r_wr_ptr;
  logic [c_ADDR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_ENT_W-1:0]   r_mem [DEPTH];

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [c_ENT_W-1:0]   w_head;
  logic [63:0]          w_head_sh;
  logic [63:0]          w_head_ct;
  logic                 w_head_pulse;
  logic [DUR_W-1:0]     w_head_dur;
  logic [DUR_W-1:0]     w_head_len;

  // An abort in the same cycle discards any push; a pop happens only when
  // the engine is free to issue (IDLE, or GAP handing straight to the next).
  assign w_full       = (r_count == c_FULL);
  assign cmd_ready    = ~w_full;
  assign w_push       = cmd_valid & ~w_full & ~abort;
  assign w_pop        = (r_count != '0) & enable & ~abort &
                        ((r_state == ST_IDLE) | (r_state == ST_GAP));

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_sh    = w_head[c_ENT_W-1 -: 64];
  assign w_head_ct    = w_head[DUR_W+64 -: 64];
  assign w_head_pulse = w_head[DUR_W];
  assign w_head_dur   = w_head[DUR_W-1:0];
  assign w_head_len   = (w_head_dur == '0) ? DUR_W'(1) : w_head_dur;

  // Strobes are registered but masked by abort in the very cycle it is seen.
  assign update       = r_update & ~abort;
  assign wait_expired = r_wait & ~abort;
  assign busy         = (r_count != '0) | (r_state != ST_IDLE);
  assign overflow     = r_overflow;

  // Command storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_shutter, cmd_counter, cmd_pulse, cmd_duration};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (abort) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (cmd_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Issue engine: ISSUE strobes update, GAP guarantees one low cycle (and may
  // issue the next command directly), TIMING counts the pulse down to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_pend_len    <= '0;
      r_update      <= 1'b0;
      r_wait        <= 1'b0;
      pulse_mode    <= 1'b0;
      shutter_value <= '0;
      counter_value <= '0;
    end else if (abort) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_update   <= 1'b0;
      r_wait     <= 1'b0;
      pulse_mode <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_wait   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_pop) begin
            r_state       <= ST_ISSUE;
            r_update      <= 1'b1;
            pulse_mode    <= w_head_pulse;
            shutter_value <= w_head_sh;
            counter_value <= w_head_ct;
            r_pend_len    <= w_head_len;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (pulse_mode) begin
            r_state <= ST_TIMING;
            r_timer <= r_pend_len;
            r_wait  <= (r_pend_len == DUR_W'(1));
          end else begin
            r_state <= ST_GAP;
          end
        end
        ST_TIMING: begin
          if (r_timer <= DUR_W'(1)) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer - DUR_W'(1);
            r_wait  <= (r_timer == DUR_W'(2));
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_pulse_scheduler
// Description : Directed scenarios followed by randomized traffic, all checked
//               cycle by cycle against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_pulse_scheduler;

  localparam int DEPTH = 4;
  localparam int DUR_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [63:0]      cmd_shutter = '0;
  logic [63:0]      cmd_counter = '0;
  logic             cmd_pulse = 1'b0;
  logic [DUR_W-1:0] cmd_duration = '0;
  logic             enable = 1'b0;
  logic             abort = 1'b0;
  logic             update;
  logic             pulse_mode;
  logic [63:0]      shutter_value;
  logic [63:0]      counter_value;
  logic             wait_expired;
  logic             busy;
  logic             overflow;

  output_pulse_scheduler #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shutter(cmd_shutter), .cmd_counter(cmd_counter),
    .cmd_pulse(cmd_pulse), .cmd_duration(cmd_duration),
    .enable(enable), .abort(abort),
    .update(update), .pulse_mode(pulse_mode),
    .shutter_value(shutter_value), .counter_value(counter_value),
    .wait_expired(wait_expired), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      sh;
    logic [63:0]      ct;
    logic             p;
    logic [DUR_W-1:0] d;
  } cmd_t;

  // Reference model: a command queue plus the cycle numbers at which the
  // next strobes are due and from which a new issue decision may be made.
  cmd_t        mq[$];
  longint      cyc;
  longint      upd_at, exp_at, free_from, busy_end;
  logic        m_ovf, m_pm;
  logic [63:0] m_sh, m_ct;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_upd = 0;
  int          n_exp = 0;
  longint      upd_cyc, exp_cyc;
  logic [63:0] obs_sh[$];
  longint      obs_cyc[$];

  function automatic void model_reset();
    mq.delete();
    upd_at    = -1;
    exp_at    = -1;
    busy_end  = -1;
    free_from = cyc;
    m_ovf     = 1'b0;
    m_pm      = 1'b0;
    m_sh      = '0;
    m_ct      = '0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model using
  // the inputs that the DUT samples on the coming edge.
  task automatic cycle();
    int     sz;
    longint dur;
    cmd_t   h;
    @(negedge clk);
    chk("update", update, (cyc == upd_at) && !abort);
    chk("wait_expired", wait_expired, (cyc == exp_at) && !abort);
    chk("pulse_mode", pulse_mode, m_pm);
    chk("shutter_value", shutter_value, m_sh);
    chk("counter_value", counter_value, m_ct);
    chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
    chk("busy", busy, (mq.size() != 0) || (cyc <= busy_end));
    chk("overflow", overflow, m_ovf);
    chk("update_and_expired", update & wait_expired, 1'b0);
    if (update === 1'b1) begin
      n_upd++;
      upd_cyc = cyc;
      obs_sh.push_back(shutter_value);
      obs_cyc.push_back(cyc);
    end
    if (wait_expired === 1'b1) begin
      n_exp++;
      exp_cyc = cyc;
    end
    if (abort) begin
      mq.delete();
      m_ovf     = 1'b0;
      m_pm      = 1'b0;
      upd_at    = -1;
      exp_at    = -1;
      busy_end  = -1;
      free_from = cyc + 1;
    end else begin
      sz = mq.size();
      if (cmd_valid && sz >= DEPTH) m_ovf = 1'b1;
      if (cyc >= free_from && sz > 0 && enable) begin
        h      = mq.pop_front();
        m_sh   = h.sh;
        m_ct   = h.ct;
        m_pm   = h.p;
        dur    = (h.d == '0) ? 64'sd1 : longint'(h.d);
        upd_at = cyc + 1;
        if (h.p) begin
          exp_at    = cyc + 1 + dur;
          busy_end  = exp_at;
          free_from = exp_at + 1;
        end else begin
          busy_end  = cyc + 2;
          free_from = cyc + 2;
        end
      end
      if (cmd_valid && sz < DEPTH) begin
        h.sh = cmd_shutter;
        h.ct = cmd_counter;
        h.p  = cmd_pulse;
        h.d  = cmd_duration;
        mq.push_back(h);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [63:0] sh, input logic [63:0] ct,
                      input logic p, input logic [DUR_W-1:0] d);
    cmd_valid    = 1'b1;
    cmd_shutter  = sh;
    cmd_counter  = ct;
    cmd_pulse    = p;
    cmd_duration = d;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_update"}, update, 1'b0);
    chk({tag, "_wait_expired"}, wait_expired, 1'b0);
    chk({tag, "_pulse_mode"}, pulse_mode, 1'b0);
    chk({tag, "_shutter"}, shutter_value, 64'h0);
    chk({tag, "_counter"}, counter_value, 64'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint c0;
    int     bu, be;
    cyc = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    run(2);

    // Single pulse, duration 5
    enable = 1'b1;
    c0 = cyc; bu = n_upd; be = n_exp;
    push(64'hFF, 64'h1, 1'b1, 5);
    run(7);
    chk("t1_update_count", n_upd - bu, 1);
    chk("t1_expired_count", n_exp - be, 1);
    chk("t1_update_cycle", upd_cyc - c0, 2);
    chk("t1_expired_cycle", exp_cyc - upd_cyc, 5);
    chk("t1_busy_after", busy, 1'b0);

    // Three static commands back to back
    run(3);
    obs_sh.delete(); obs_cyc.delete();
    c0 = cyc; be = n_exp;
    push(64'h11, 64'h1, 1'b0, 7);
    push(64'h22, 64'h2, 1'b0, 0);
    push(64'h33, 64'h3, 1'b0, 3);
    run(8);
    chk("t2_update_count", obs_sh.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_sh.size()) begin
        chk("t2_order", obs_sh[i], 64'h11 * (i + 1));
        chk("t2_spacing", obs_cyc[i] - c0, 2 + 2 * i);
      end
    end
    chk("t2_no_expired", n_exp - be, 0);

    // Fill while disabled, overflow, then drain
    enable = 1'b0;
    run(2);
    obs_sh.delete(); obs_cyc.delete();
    bu = n_upd;
    for (int i = 1; i <= 4; i++) push(64'(i), 64'h0, 1'b0, 0);
    chk("t3_ready_low", cmd_ready, 1'b0);
    chk("t3_no_overflow_yet", overflow, 1'b0);
    push(64'h5, 64'h0, 1'b0, 0);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_held", n_upd - bu, 0);
    enable = 1'b1;
    run(15);
    chk("t3_update_count", n_upd - bu, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_sh.size()) chk("t3_order", obs_sh[i], 64'(i + 1));
    end

    // Duration 0 and 1 both expire one cycle after update
    run(2);
    c0 = cyc;
    push(64'hA0, 64'h0, 1'b1, 0);
    run(5);
    chk("t4_d0_update", upd_cyc - c0, 2);
    chk("t4_d0_expired", exp_cyc - upd_cyc, 1);
    c0 = cyc;
    push(64'hA1, 64'h0, 1'b1, 1);
    run(5);
    chk("t4_d1_update", upd_cyc - c0, 2);
    chk("t4_d1_expired", exp_cyc - upd_cyc, 1);

    // Abort mid-pulse with commands queued
    bu = n_upd; be = n_exp;
    push(64'hB0, 64'h0, 1'b1, 20);
    for (int i = 0; i < 5; i++) push(64'hC0 + 64'(i), 64'h0, 1'b0, 0);
    run(3);
    chk("t5_overflow_before", overflow, 1'b1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_overflow_after", overflow, 1'b0);
    run(40);
    chk("t5_updates", n_upd - bu, 1);
    chk("t5_no_expired", n_exp - be, 0);

    // Asynchronous reset mid-pulse
    push(64'hDEAD, 64'hBEEF, 1'b1, 30);
    run(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    bu = n_upd; be = n_exp;
    run(30);
    chk("t6_no_update", n_upd - bu, 0);
    chk("t6_no_expired", n_exp - be, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cmd_valid    = ($urandom_range(0, 99) < 45);
      cmd_shutter  = {$urandom, $urandom};
      cmd_counter  = {$urandom, $urandom};
      cmd_pulse    = 1'($urandom_range(0, 1));
      cmd_duration = DUR_W'($urandom_range(0, 6));
      enable       = ($urandom_range(0, 99) < 85);
      abort        = ($urandom_range(0, 99) < 3);
      cycle();
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    enable    = 1'b1;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
